// File: rtl/spi_mem_bridge_if.sv
// SPI pin bundle for spi_mem_bridge: the SPI master side plus the status pins.
interface spi_mem_bridge_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  cs;
   logic                  sck;
   logic                  mosi;
   logic                  miso;
   logic                  miso_oe;
   logic [DATA_WIDTH-1:0] led_out;
   logic                  busy;
   logic                  frame_err;

   modport master (
      output cs, sck, mosi,
      input  miso, miso_oe, led_out, busy, frame_err
   );

   modport slave (
      input  cs, sck, mosi,
      output miso, miso_oe, led_out, busy, frame_err
   );
endinterface

// File: rtl/spi_mem_bridge.sv
// SPI peripheral giving an external master burst read/write access to a
// register memory. Everything runs on clk; cs/sck/mosi are oversampled.
// Frame: {write flag, start address} header, then auto-incrementing words.
module spi_mem_bridge #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 8,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int SYNC_STAGES = 2
) (
   input logic              clk,
   input logic              reset,
   spi_mem_bridge_if.slave  bus
);

   localparam int HDR_BITS = ADDR_WIDTH + 1;
   localparam int RX_BITS  = (HDR_BITS > DATA_WIDTH) ? HDR_BITS : DATA_WIDTH;
   localparam int CNT_BITS = $clog2(RX_BITS + 1);
   localparam logic [CNT_BITS-1:0] HDR_LAST  = CNT_BITS'(HDR_BITS - 1);
   localparam logic [CNT_BITS-1:0] WORD_LAST = CNT_BITS'(DATA_WIDTH - 1);
   localparam bit SAMPLE_RISE = (CPOL == CPHA);

   typedef enum logic [1:0] {IDLE, HEADER, WRITE, READ} state_t;
   state_t state, stateNext;

   logic [SYNC_STAGES-1:0] csSync, sckSync, mosiSync;
   logic                   csS, sckS, mosiS;
   logic                   csPrev, sckPrev;
   logic                   csFall, csRise, sampleEdge, shiftEdge;

   logic [CNT_BITS-1:0]    bitCnt;
   logic [RX_BITS-2:0]     rxReg;
   logic [RX_BITS-1:0]     rxNext;
   logic [ADDR_WIDTH-1:0]  addr, addrNext;
   logic [DATA_WIDTH-1:0]  memRd, txReg;
   logic                   txLoad, misoReg, misoOeReg, frameErrReg;
   logic                   hdrDone, wordDone, fetch, memWe;

   logic [DATA_WIDTH-1:0]  mem [2**ADDR_WIDTH];

   // Synchronisers and sck history; no reset needed on pure sampling flops.
   always_ff @(posedge clk) begin
      csSync   <= {csSync[SYNC_STAGES-2:0], bus.cs};
      sckSync  <= {sckSync[SYNC_STAGES-2:0], bus.sck};
      mosiSync <= {mosiSync[SYNC_STAGES-2:0], bus.mosi};
      sckPrev  <= sckS;
   end

   assign csS   = csSync[SYNC_STAGES-1];
   assign sckS  = sckSync[SYNC_STAGES-1];
   assign mosiS = mosiSync[SYNC_STAGES-1];

   // csPrev resets low so a cs held low across reset never looks like a fall.
   assign csFall     = csPrev & ~csS;
   assign csRise     = ~csPrev & csS;
   assign sampleEdge = SAMPLE_RISE ? (sckS & ~sckPrev) : (~sckS & sckPrev);
   assign shiftEdge  = SAMPLE_RISE ? (~sckS & sckPrev) : (sckS & ~sckPrev);

   assign rxNext   = {rxReg, mosiS};
   assign hdrDone  = (state == HEADER) && sampleEdge && (bitCnt == HDR_LAST);
   assign wordDone = ((state == WRITE) || (state == READ)) && sampleEdge &&
                     (bitCnt == WORD_LAST);
   assign memWe    = wordDone && (state == WRITE);
   assign fetch    = hdrDone || wordDone;
   assign addrNext = hdrDone ? rxNext[ADDR_WIDTH-1:0] : addr + ADDR_WIDTH'(1);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   // Next-state: header picks the burst direction, cs rise always aborts.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (csFall)  stateNext = HEADER;
         HEADER:  if (hdrDone) stateNext = rxNext[HDR_BITS-1] ? WRITE : READ;
         default: ;
      endcase
      if (csRise) stateNext = IDLE;
   end

   // Memory array; word 0 is cleared by reset because it drives led_out.
   always_ff @(posedge clk) begin
      if (reset)      mem[0]    <= '0;
      else if (memWe) mem[addr] <= rxNext[DATA_WIDTH-1:0];
   end

   // Bit counting, address walk, registered fetch and miso shifting.
   always_ff @(posedge clk) begin
      if (reset) begin
         csPrev      <= 1'b0;
         bitCnt      <= '0;
         rxReg       <= '0;
         addr        <= '0;
         memRd       <= '0;
         txLoad      <= 1'b0;
         txReg       <= '0;
         misoReg     <= 1'b0;
         misoOeReg   <= 1'b0;
         frameErrReg <= 1'b0;
      end else begin
         csPrev      <= csS;
         misoOeReg   <= ~csS;
         frameErrReg <= csRise && (state != IDLE) && (bitCnt != '0);
         txLoad      <= fetch;
         if (fetch) begin
            addr  <= addrNext;
            // write-first: only collides when the address space is one word
            memRd <= (memWe && (addr == addrNext)) ? rxNext[DATA_WIDTH-1:0]
                                                   : mem[addrNext];
         end
         if ((state == IDLE) || csRise) begin
            bitCnt <= '0;
         end else if (sampleEdge) begin
            rxReg  <= rxNext[RX_BITS-2:0];
            bitCnt <= fetch ? '0 : bitCnt + CNT_BITS'(1);
         end
         if ((state == WRITE) || (state == READ)) begin
            if (txLoad) begin
               txReg <= memRd;
            end else if (shiftEdge) begin
               misoReg <= txReg[DATA_WIDTH-1];
               txReg   <= {txReg[DATA_WIDTH-2:0], 1'b0};
            end
         end else begin
            misoReg <= 1'b0;
         end
      end
   end

   assign bus.miso      = misoReg;
   assign bus.miso_oe   = misoOeReg;
   assign bus.led_out   = mem[0];
   assign bus.busy      = (state != IDLE);
   assign bus.frame_err = frameErrReg;

endmodule
